branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 6, giving log2 of the number of pattern-table entries.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port f_pc, input, 32 bits: fetch-stage PC to predict.
REQ-005 The block SHALL have port f_pred_taken, output, 1 bit: combinational prediction for f_pc.
REQ-006 The block SHALL have port u_valid, input, 1 bit: a conditional branch resolves this cycle.
REQ-007 The block SHALL have port u_pc, input, 32 bits: PC of the resolving branch.
REQ-008 The block SHALL have port u_taken, input, 1 bit: actual outcome from the branch comparator.
REQ-009 The block SHALL have port u_pred_taken, input, 1 bit: prediction carried down the pipe with that branch.
REQ-010 The block SHALL have port mispredict, output, 1 bit: registered mispredict pulse.
REQ-011 The block SHALL have port mispredict_taken, output, 1 bit: registered correct direction, valid while mispredict=1.
REQ-012 The block SHALL have port br_count, output, 32 bits: resolved-branch counter.
REQ-013 The block SHALL have port miss_count, output, 32 bits: mispredict counter.

Function
REQ-014 The pattern table SHALL hold 2^IDX_W 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 The base read index SHALL be f_pc[IDX_W+1:2], and the base update index SHALL be u_pc[IDX_W+1:2].
REQ-016 f_pred_taken SHALL equal bit 1 of the indexed counter, with zero-cycle latency.
REQ-017 When u_valid=1, the indexed counter SHALL increment (saturating at 11) if u_taken=1, otherwise decrement (saturating at 00), at the next edge.
REQ-018 When the read and update indices coincide in one cycle, f_pred_taken SHALL reflect the pre-update value, with no bypass.
REQ-019 When u_valid=1 and u_taken!=u_pred_taken, mispredict SHALL be 1 in the following cycle, and mispredict_taken SHALL equal u_taken; otherwise mispredict SHALL be 0 for exactly one cycle per event.
REQ-020 When u_valid=1, br_count SHALL increment by 1, and miss_count SHALL also increment on a mispredict; both SHALL saturate at 32'hFFFF_FFFF without wrapping.
REQ-021 When u_valid=0, the table, the counters and the history SHALL be unchanged.
REQ-022 The block SHALL accept at most one update per cycle, and back-to-back updates to the same index SHALL each apply in order.

Reset
REQ-023 While rst=1, every table counter SHALL load 01 at the edge.
REQ-024 While rst=1, mispredict, mispredict_taken, br_count, miss_count and the history register SHALL load 0.
REQ-025 An update presented in a cycle with rst=1 SHALL be discarded.
REQ-026 f_pred_taken SHALL read 0 in the first cycle after reset release.

Configuration
REQ-027 The macro BP_GSHARE_EN SHALL select the indexing scheme.
REQ-028 When BP_GSHARE_EN is defined, an IDX_W-bit global history register SHALL shift in u_taken at LSB on each u_valid, non-speculatively.
REQ-029 When BP_GSHARE_EN is defined, both the read and update indices SHALL be the base index XOR the history register.
REQ-030 When BP_GSHARE_EN is undefined, no history register SHALL exist, and indexing SHALL be pure PC bits.

Verification
REQ-031 Reset, then f_pc=0x0000_0040 -> f_pred_taken=0; br_count=0; miss_count=0.
REQ-032 Three updates u_pc=0x40, u_taken=1, u_pred_taken=0 on consecutive cycles -> counter 01->10->11->11; mispredict=1 for 3 cycles; f_pc=0x40 predicts 1; miss_count=3.
REQ-033 Same-cycle f_pc=u_pc=0x80, counter at 01, u_taken=1 -> f_pred_taken=0 that cycle and 1 the next.
REQ-034 Aliasing: update u_pc=0x100 taken twice with IDX_W=6 (0x100 aliases 0x000) -> f_pc=0x000 predicts 1, and without BP_GSHARE_EN other entries stay 01.
REQ-035 Assert rst during a u_valid=1 mispredicting update -> mispredict=0 next cycle; counts 0; table all 01.
REQ-036 Preload br_count=0xFFFF_FFFE, then 3 updates -> br_count holds 0xFFFF_FFFF; with BP_GSHARE_EN defined, history after taken,NT,taken = 6'b000101.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor with hit/miss counters.
// Define BP_GSHARE_EN to XOR a non-speculative global history into both table indices.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic        u_pred_taken,
  output logic        mispredict,
  output logic        mispredict_taken,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);
  localparam int N = 1 << IDX_W;
  logic [1:0] tbl_q [N];
  logic [IDX_W-1:0] ridx, uidx;
  logic [1:0] ctr, ctr_d;
  logic miss, mispredict_q, mispredict_taken_q;
  logic [31:0] br_count_q, br_count_d, miss_count_q, miss_count_d;
`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] hist_q;
  assign ridx = f_pc[IDX_W+1:2] ^ hist_q;
  assign uidx = u_pc[IDX_W+1:2] ^ hist_q;
  always_ff @(posedge clk)
    if (rst) hist_q <= '0;
    else if (u_valid) hist_q <= {hist_q[IDX_W-2:0], u_taken};
`else
  assign ridx = f_pc[IDX_W+1:2];
  assign uidx = u_pc[IDX_W+1:2];
`endif
  // Read port sees the pre-update counter; no write-to-read bypass.
  assign f_pred_taken = tbl_q[ridx][1];
  always_comb begin
    ctr = tbl_q[uidx];
    ctr_d = u_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1) : (ctr == 2'b00 ? ctr : ctr - 2'd1);
    miss = u_valid & (u_taken ^ u_pred_taken);
    br_count_d = (u_valid && ~&br_count_q) ? br_count_q + 32'd1 : br_count_q;
    miss_count_d = (miss && ~&miss_count_q) ? miss_count_q + 32'd1 : miss_count_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= 2'b01;
      mispredict_q <= 1'b0;
      mispredict_taken_q <= 1'b0;
      br_count_q <= '0;
      miss_count_q <= '0;
    end else begin
      if (u_valid) tbl_q[uidx] <= ctr_d;
      mispredict_q <= miss;
      mispredict_taken_q <= miss & u_taken;
      br_count_q <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  assign mispredict = mispredict_q;
  assign mispredict_taken = mispredict_taken_q;
  assign br_count = br_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench; a reference table/history/counter model predicts every cycle.
module tb_branch_predictor;
  logic clk = 1'b0, rst = 1'b1, u_valid = 1'b0, u_taken = 1'b0, u_pred_taken = 1'b0;
  logic [31:0] f_pc = '0, u_pc = '0;
  logic f_pred_taken, mispredict, mispredict_taken;
  logic [31:0] br_count, miss_count;
  int n = 0, errs = 0;

  typedef struct packed {
    logic m;
    logic t;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  logic [1:0] mtbl [64];
  logic [5:0] mhist;
  logic [31:0] mbr, mmiss;

  branch_predictor #(.IDX_W(6)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_pred_taken(u_pred_taken),
    .mispredict(mispredict), .mispredict_taken(mispredict_taken),
    .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] midx(input logic [31:0] pc);
    return pc[7:2] ^ mhist;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mtbl[i] = 2'b01;
    mhist = '0;
    mbr = '0;
    mmiss = '0;
  endtask

  task automatic idle();
    rst = 1'b0;
    u_valid = 1'b0;
    sbq.push_back('{1'b0, 1'b0, mbr, mmiss});
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic p);
    logic [5:0] k;
    logic ms;
    rst = 1'b0;
    u_valid = 1'b1;
    u_pc = pc;
    u_taken = t;
    u_pred_taken = p;
    k = midx(pc);
    ms = t ^ p;
    if (t && mtbl[k] != 2'b11) mtbl[k] = mtbl[k] + 2'd1;
    if (!t && mtbl[k] != 2'b00) mtbl[k] = mtbl[k] - 2'd1;
`ifdef BP_GSHARE_EN
    mhist = {mhist[4:0], t};
`endif
    if (mbr != 32'hFFFF_FFFF) mbr = mbr + 32'd1;
    if (ms && mmiss != 32'hFFFF_FFFF) mmiss = mmiss + 32'd1;
    sbq.push_back('{ms, t, mbr, mmiss});
  endtask

  task automatic do_reset(input logic with_upd);
    rst = 1'b1;
    u_valid = with_upd;
    u_pc = 32'h40;
    u_taken = 1'b1;
    u_pred_taken = 1'b0;
    model_reset();
    sbq.push_back('{1'b0, 1'b0, 32'd0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    u_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n++;
      if (mispredict !== e.m) begin errs++; $display("FAIL mispredict got %b want %b", mispredict, e.m); end
      if (e.m) begin
        n++;
        if (mispredict_taken !== e.t) begin errs++; $display("FAIL mispredict_taken got %b want %b", mispredict_taken, e.t); end
      end
      n++;
      if (br_count !== e.b) begin errs++; $display("FAIL br_count got %h want %h", br_count, e.b); end
      n++;
      if (miss_count !== e.c) begin errs++; $display("FAIL miss_count got %h want %h", miss_count, e.c); end
    end
  end

  task automatic test_reset();
    do_reset(1'b0);
    f_pc = 32'h40;
    #1;
    n++;
    if (f_pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pred got %b want 0", f_pred_taken); end
    n++;
    if (br_count !== 32'd0 || miss_count !== 32'd0) begin errs++; $display("FAIL reset_counts got %h/%h want 0/0", br_count, miss_count); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin upd(32'h40, 1'b1, 1'b0); @(negedge clk); end
    idle();
    f_pc = 32'h40;
    #1;
    n++;
    if (f_pred_taken !== mtbl[midx(f_pc)][1]) begin errs++; $display("FAIL b2b_pred got %b want %b", f_pred_taken, mtbl[midx(f_pc)][1]); end
`ifndef BP_GSHARE_EN
    n++;
    if (f_pred_taken !== 1'b1 || mtbl[16] !== 2'b11) begin errs++; $display("FAIL b2b_sat got %b want 1", f_pred_taken); end
`endif
    n++;
    if (miss_count !== 32'd3) begin errs++; $display("FAIL b2b_miss got %h want 3", miss_count); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin upd(32'h40, 1'b0, 1'b1); @(negedge clk); end
    for (int i = 0; i < 3; i++) begin upd(32'h44, i[0], 1'b0); @(negedge clk); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic pre;
    do_reset(1'b0);
    f_pc = 32'h80;
    pre = mtbl[midx(f_pc)][1];
    upd(32'h80, 1'b1, 1'b0);
    #1;
    n++;
    if (f_pred_taken !== pre || f_pred_taken !== 1'b0) begin errs++; $display("FAIL same_pre got %b want 0", f_pred_taken); end
    @(negedge clk);
    idle();
    #1;
    n++;
    if (f_pred_taken !== mtbl[midx(f_pc)][1]) begin errs++; $display("FAIL same_post got %b want %b", f_pred_taken, mtbl[midx(f_pc)][1]); end
`ifndef BP_GSHARE_EN
    n++;
    if (f_pred_taken !== 1'b1) begin errs++; $display("FAIL same_post_c got %b want 1", f_pred_taken); end
`endif
    @(negedge clk);
  endtask

  task automatic test_alias();
    do_reset(1'b0);
    upd(32'h100, 1'b1, 1'b1);
    @(negedge clk);
    upd(32'h100, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    for (int i = 0; i < 64; i++) begin
      f_pc = i << 2;
      #1;
      n++;
      if (f_pred_taken !== mtbl[midx(f_pc)][1]) begin errs++; $display("FAIL alias_scan[%0d] got %b want %b", i, f_pred_taken, mtbl[midx(f_pc)][1]); end
    end
`ifndef BP_GSHARE_EN
    f_pc = 32'h0;
    #1;
    n++;
    if (f_pred_taken !== 1'b1) begin errs++; $display("FAIL alias_zero got %b want 1", f_pred_taken); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_during_update();
    upd(32'h40, 1'b1, 1'b0);
    @(negedge clk);
    do_reset(1'b1);
    idle();
    for (int i = 0; i < 64; i++) begin
      f_pc = i << 2;
      #1;
      n++;
      if (f_pred_taken !== 1'b0) begin errs++; $display("FAIL rst_scan[%0d] got %b want 0", i, f_pred_taken); end
    end
    n++;
    if (mispredict !== 1'b0 || br_count !== 32'd0 || miss_count !== 32'd0) begin
      errs++; $display("FAIL rst_upd got %b/%h/%h want 0/0/0", mispredict, br_count, miss_count);
    end
    @(negedge clk);
  endtask

  task automatic test_count_saturation();
    do_reset(1'b0);
    force dut.br_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_q;
    mbr = 32'hFFFF_FFFE;
    upd(32'h0, 1'b1, 1'b1);
    @(negedge clk);
    upd(32'h4, 1'b0, 1'b0);
    @(negedge clk);
    upd(32'h8, 1'b1, 1'b1);
    @(negedge clk);
    idle();
    #1;
    n++;
    if (br_count !== 32'hFFFF_FFFF) begin errs++; $display("FAIL br_sat got %h want ffffffff", br_count); end
`ifdef BP_GSHARE_EN
    n++;
    if (dut.hist_q !== 6'b000101) begin errs++; $display("FAIL hist got %b want 000101", dut.hist_q); end
`endif
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_same_cycle();
    test_alias();
    test_reset_during_update();
    test_count_saturation();
    idle();
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
